// File: rtl/img_mem_responder.sv
// Image-memory responder: splits each 32-bit processor access into two 16-bit
// halfword accesses and stalls the processor until the word is complete.
module img_mem_responder #(
  parameter int          MBUS   = 32,
  parameter int          DBITS  = 16,
  parameter int          ABITS  = 15,
  parameter logic [15:0] REGION = 16'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MBUS-1:0]  addr,
  input  logic [MBUS-1:0]  wdata,
  input  logic             we,
  input  logic             re,
  output logic [MBUS-1:0]  rdata,
  output logic             stall,
  output logic             mem_en,
  output logic             mem_we,
  output logic             mem_re,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             err
);

  localparam int WBITS = ABITS - 1;

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [WBITS-1:0]   w_reg;
  logic [DBITS-1:0]   wdata_hi_reg;
  logic [DBITS-1:0]   lo_buf;
  logic               hit;
  logic               mem_we_next, mem_re_next;
  logic [ABITS-1:0]   mem_addr_next;
  logic [DBITS-1:0]   mem_wdata_next;

  // Byte offset is ignored: only whole-word accesses exist on this path.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  assign hit = (we | re) & (addr[MBUS-1:16] == REGION);

  // Held-in-reset requests must not stall the processor.
  assign stall = rst & (((state_reg == IDLE) & hit) |
                        ((state_reg != IDLE) & (state_reg != DONE)));

  always_comb begin
    state_next     = state_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          state_next    = we ? WR_LO : RD_LO;
          mem_we_next   = we;
          mem_re_next   = ~we;
          mem_addr_next = {addr[WBITS+1:2], 1'b0};
          if (we) mem_wdata_next = wdata[DBITS-1:0];
        end
      end
      WR_LO: begin
        state_next     = WR_HI;
        mem_we_next    = 1'b1;
        mem_addr_next  = {w_reg, 1'b1};
        mem_wdata_next = wdata_hi_reg;
      end
      WR_HI:  state_next = DONE;
      RD_LO: begin
        state_next    = RD_HI;
        mem_re_next   = 1'b1;
        mem_addr_next = {w_reg, 1'b1};
      end
      RD_HI:  state_next = RD_CAP;
      RD_CAP: state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      w_reg        <= '0;
      wdata_hi_reg <= '0;
      lo_buf       <= '0;
      rdata        <= '0;
      err          <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_reg <= state_next;
      mem_we    <= mem_we_next;
      mem_re    <= mem_re_next;
      mem_en    <= mem_we_next | mem_re_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      if (state_reg == IDLE && hit) begin
        w_reg        <= addr[WBITS+1:2];
        wdata_hi_reg <= wdata[2*DBITS-1:DBITS];
        if (we && re) err <= 1'b1;
      end
      // Read data lands one cycle after each strobe: low half in RD_HI,
      // high half in RD_CAP, where the full word is assembled for DONE.
      if (state_reg == RD_HI)  lo_buf <= mem_rdata;
      if (state_reg == RD_CAP) rdata  <= {mem_rdata, lo_buf};
    end
  end

endmodule

// File: tb/tb_img_mem_responder.sv
// Directed + randomized bench for img_mem_responder with a halfword memory
// model and a word-level reference of what each read must return.
module tb_img_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        stall, mem_en, mem_we, mem_re, err;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:32767];
  logic [31:0] ref_word [int];
  int          known_w [$];
  logic [31:0] rdata_exp = '0;
  logic        err_exp = 1'b0;

  always #5 clk = ~clk;

  img_mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  // Halfword memory: read data is valid only in the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_en && mem_re) ? mem[mem_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[2*w]     = v[15:0];
    mem[2*w + 1] = v[31:16];
    ref_word[w]  = v;
    known_w.push_back(w);
  endtask

  // One processor access on the image region, checked cycle by cycle.
  task automatic access(input logic do_wr, input logic do_rd,
                        input logic [31:0] a, input logic [31:0] d);
    int w, lat;
    logic wr;
    wr  = do_wr;
    w   = int'(a[15:2]);
    lat = wr ? 3 : 4;
    @(negedge clk);
    addr = a; wdata = d; we = do_wr; re = do_rd;
    if (do_wr && do_rd) err_exp = 1'b1;
    for (int k = 0; k < lat; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("stall_c%0d", k), {31'b0, stall}, 32'd1);
      if (k == 1 || k == 2) begin
        check($sformatf("mem_en_c%0d", k), {31'b0, mem_en}, 32'd1);
        check($sformatf("mem_we_c%0d", k), {31'b0, mem_we}, {31'b0, wr});
        check($sformatf("mem_re_c%0d", k), {31'b0, mem_re}, {31'b0, ~wr});
        check($sformatf("mem_addr_c%0d", k), {17'b0, mem_addr}, 32'(2*w + k - 1));
        if (wr)
          check($sformatf("mem_wdata_c%0d", k), {16'b0, mem_wdata},
                (k == 1) ? {16'b0, d[15:0]} : {16'b0, d[31:16]});
      end else begin
        check($sformatf("mem_en_c%0d", k), {31'b0, mem_en}, 32'd0);
      end
    end
    if (wr) begin
      ref_word[w] = d;
      known_w.push_back(w);
    end else begin
      rdata_exp = ref_word.exists(w) ? ref_word[w] : {mem[2*w + 1], mem[2*w]};
    end
    @(negedge clk);
    #1;
    check("done_stall", {31'b0, stall}, 32'd0);
    check("done_mem_en", {31'b0, mem_en}, 32'd0);
    check("done_rdata", rdata, rdata_exp);
    check("done_err", {31'b0, err}, {31'b0, err_exp});
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;

    // Reset held with a hit request pending.
    addr = 32'h0001_0008; wdata = 32'hBEEF_CAFE; we = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mem", {29'b0, mem_en, mem_we, mem_re}, 32'd0);
    check("rst_addr", {17'b0, mem_addr}, 32'd0);
    check("rst_wdata", {16'b0, mem_wdata}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_stall", {31'b0, stall}, 32'd1);
    we = 1'b0;

    // Directed write then read of the same word.
    access(1'b1, 1'b0, 32'h0001_0008, 32'hBEEF_CAFE);
    preload(2, 32'h5678_1234);
    access(1'b0, 1'b1, 32'h0001_0008, 32'h0);
    check("read_value", rdata, 32'h5678_1234);
    access(1'b1, 1'b0, 32'h0001_0010, 32'h1111_2222);
    check("rdata_after_write", rdata, 32'h5678_1234);

    // Miss: no stall, no memory cycle, rdata unchanged.
    @(negedge clk);
    addr = 32'h0000_0010; re = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("miss_stall", {31'b0, stall}, 32'd0);
      check("miss_mem_en", {31'b0, mem_en}, 32'd0);
      check("miss_rdata", rdata, 32'h5678_1234);
      @(negedge clk);
    end
    re = 1'b0;

    // Conflicting we/re: write wins, err sticks.
    access(1'b1, 1'b1, 32'h0001_0020, 32'hA5A5_5A5A);
    access(1'b0, 1'b1, 32'h0001_0020, 32'h0);
    check("conflict_wrote", rdata, 32'hA5A5_5A5A);

    // Randomized accesses with random byte offsets.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, d;
      a = {16'h0001, 14'($urandom_range(0, 63)), 2'($urandom)};
      d = $urandom;
      if (($urandom & 1) == 0 || known_w.size() == 0) begin
        access(1'b1, 1'b0, a, d);
      end else begin
        a[15:2] = 14'(known_w[$urandom_range(0, known_w.size() - 1)]);
        access(1'b0, 1'b1, a, d);
      end
    end
    check("err_sticky", {31'b0, err}, 32'd1);

    // Reset during RD_HI abandons the read and clears everything.
    @(negedge clk);
    addr = 32'h0001_0008; re = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_mem_re", {31'b0, mem_re}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_mem_re", {31'b0, mem_re}, 32'd0);
    check("midrst_mem_en", {31'b0, mem_en}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    err_exp = 1'b0;
    rdata_exp = 32'd0;
    access(1'b0, 1'b1, 32'h0001_0008, 32'h0);
    check("post_rst_read", rdata, ref_word[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_mem_responder.md
Name: img_mem_responder

Overview:
- Memory-side responder for processor data accesses (MWE/MRE, addressData, storeData, loadedData).
- Decodes the image region and splits each 32-bit processor word into two 16-bit accesses on the image Memory port (15-bit halfword address).
- For reads, it reassembles the two halves into a 32-bit word.
- Holds the processor with `stall` until the access completes.

Parameters:
- `MBUS`, 32, processor data/address width.
- `DBITS`, 16, image memory data width.
- `ABITS`, 15, image memory address width.
- `REGION`, 16'h0001, value of `addr[31:16]` that selects image memory.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  32  processor byte address (addressData).
- `wdata`  in  32  processor store data (storeData).
- `we`  in  1  processor write request (MWE), level, held while `stall`=1.
- `re`  in  1  processor read request (MRE), level, held while `stall`=1.
- `rdata`  out  32  assembled read word (loadedData).
- `stall`  out  1  processor must hold request and PC while high.
- `mem_en`  out  1  image memory enable.
- `mem_we`  out  1  image memory write enable.
- `mem_re`  out  1  image memory read enable.
- `mem_addr`  out  15  halfword address.
- `mem_wdata`  out  16  halfword write data.
- `mem_rdata`  in  16  halfword read data, valid exactly 1 cycle after `mem_re`.
- `err`  out  1  sticky: `we` and `re` seen high together; cleared only by reset.

Behaviour:
- Reset (`rst`=0, async) gives:
  - state=IDLE;
  - `rdata`=0, `stall`=0, `err`=0;
  - `mem_en`=`mem_we`=`mem_re`=0;
  - `mem_addr`=0, `mem_wdata`=0.
- Memory-side outputs are registered. Asserting reset mid-access drops `mem_we`/`mem_re` immediately; the access is abandoned and no partial-word recovery is done.
- Hit condition: `hit` = (`we`|`re`) & (`addr[31:16]`==`REGION`).
- Misses are ignored: `stall` stays 0, no memory cycle, `rdata` unchanged.
- Address map: word index w=`addr[15:2]`; low half at {w,1'b0}, high half at {w,1'b1}. `addr[1:0]` is ignored (word accesses only).
- Stall rule, combinational: `stall` = (state==IDLE & hit) | (state ∉ {IDLE, DONE}).
- FSM: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, DONE.
- IDLE:
  - On a hit, latch `addr[15:2]`, `wdata`, and the operation.
  - `we` has priority over `re`. If both are high, do the write and set `err`.
  - Next state is WR_LO for a write, RD_LO for a read.
- WR_LO: drive `mem_en`=1, `mem_we`=1, `mem_addr`={w,0}, `mem_wdata`=`wdata[15:0]`; go to WR_HI.
- WR_HI: drive `mem_we`=1, `mem_addr`={w,1}, `mem_wdata`=`wdata[31:16]`; go to DONE.
- RD_LO: drive `mem_en`=1, `mem_re`=1, `mem_addr`={w,0}; go to RD_HI.
- RD_HI: drive `mem_re`=1, `mem_addr`={w,1}; capture `mem_rdata` into `lo_buf`; go to RD_CAP.
- RD_CAP: `mem_re`=0; capture `mem_rdata` into `hi_buf`; go to DONE.
- DONE:
  - `stall`=0 and all mem strobes are 0.
  - For a read, `rdata`={`hi_buf`,`lo_buf`}; it is loaded on entry to DONE and is valid during DONE.
  - DONE always returns to IDLE. A request still visible in DONE is treated as the completed one and is not reissued.
- `rdata` holds its last read value until the next read reaches DONE. Writes never change `rdata`.
- Latency, request visible to release (`stall` low):
  - write: 3 stall cycles (IDLE, WR_LO, WR_HI), then DONE;
  - read: 4 stall cycles (IDLE, RD_LO, RD_HI, RD_CAP), then DONE.
- Back-to-back: a new request is accepted in the IDLE cycle directly after DONE, giving a minimum period of 4 cycles (write) or 5 cycles (read).
- Request dropped while `stall`=1 (protocol violation): the latched access completes anyway.
- `mem_en` equals `mem_we`|`mem_re`.

Test Plan:
1. Reset: hold `rst`=0 while `we`=1 with a hit address → all outputs 0; release → request accepted next edge, `stall`=1 that cycle.
2. Write: `addr`=32'h0001_0008, `wdata`=32'hBEEF_CAFE, `we`=1 → WR_LO `mem_addr`=15'h0004, `mem_wdata`=16'hCAFE; WR_HI `mem_addr`=15'h0005, `mem_wdata`=16'hBEEF; `stall` high 3 cycles, then low 1 cycle.
3. Read: memory model returns 16'h1234 @0x4 and 16'h5678 @0x5; `re`=1, `addr`=32'h0001_0008 → `rdata`=32'h5678_1234 in DONE after 4 stall cycles; `rdata` still holds that value after a following write.
4. Miss: `addr`=32'h0000_0010, `re`=1 → `stall`=0, `mem_en`=0 for 5 cycles, `rdata` unchanged.
5. Conflict: `we`=`re`=1 → write sequence only, `err`=1 and stays 1 through later clean accesses until reset.
6. Reset mid-read: assert `rst` low during RD_HI → `mem_re` drops without a clock edge, state=IDLE, `rdata`=0; the next read completes correctly.
